lfsr_seed_sequencer: RTL and testbench

Sequential stage directly upstream of the combinational LFSR segment randomiser. It holds the RNDSIZE-bit LFSR state, which is loaded once over a 32-bit word interface. It then issues one seed per frame over a valid/ready handshake, together with a latched probability code and a 4-bit frame count. Between frames it advances the state by ADVANCE LFSR steps, using the same polynomial and shift direction as the randomiser, so consecutive frames never reuse a seed.

---
 rtl/lfsr_seed_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_lfsr_seed_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seed_sequencer.sv
// rtl/lfsr_seed_sequencer.sv - LFSR seed holder and per-frame seed issuer for the segment randomiser
//
// Holds the RNDSIZE-bit LFSR state. The state is loaded once over a 32-bit
// word port, least-significant word first. It is then offered one frame at a
// time over a valid/ready handshake, and advanced by ADVANCE LFSR steps per
// accepted frame.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cfg_load          pulse: begin a seed load (honoured in IDLE/READY only)
//   cfg_word_valid    seed word present on cfg_word
//   cfg_word          32-bit seed word
//   cfg_word_ready    high while loading
//   probability_in    probability code, captured on start
//   start, stop       pulses: READY->RUN, request RUN->READY
//   frame_valid       frame (seed/probability/count) offered
//   frame_ready       downstream accepts the frame
//   seed              current LFSR state
//   probability       latched probability code
//   count             frame index, wraps at 2^COUNTERSIZE
//   busy              high in LOAD and RUN
//   zero_seed_err     sticky: the loaded seed was all-zero and was forced to 1
module lfsr_seed_sequencer #(
    parameter int NB_SEGMENTS = 7,
    parameter int BITSIZE     = 10,
    parameter int RNDSIZE     = 70,
    parameter int ADVANCE     = 1,
    parameter int COUNTERSIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_load,
    input  logic                   cfg_word_valid,
    input  logic [31:0]            cfg_word,
    output logic                   cfg_word_ready,
    input  logic [COUNTERSIZE-1:0] probability_in,
    input  logic                   start,
    input  logic                   stop,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [RNDSIZE-1:0]     seed,
    output logic [COUNTERSIZE-1:0] probability,
    output logic [COUNTERSIZE-1:0] count,
    output logic                   busy,
    output logic                   zero_seed_err
);

    localparam int NW   = (RNDSIZE + 31) / 32;
    localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;

    // The randomiser slices NB_SEGMENTS*BITSIZE bits out of the state, and
    // the feedback taps reach bit 3.
    generate
        if (RNDSIZE < NB_SEGMENTS * BITSIZE || RNDSIZE < 5 || ADVANCE < 1 || ADVANCE > RNDSIZE) begin : g_bad_cfg
            $error("lfsr_seed_sequencer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   word_idx;
    logic              stop_pending;
    logic [RNDSIZE-1:0] assembled;
    logic [RNDSIZE-1:0] advanced;
    logic              load_start;
    logic              word_fire;
    logic              last_word;
    logic              frame_fire;
    logic              run_start;

    // Same polynomial and shift direction as the downstream randomiser.
    function automatic logic [RNDSIZE-1:0] lfsr_step(input logic [RNDSIZE-1:0] s);
        logic fb;
        fb = s[RNDSIZE-1] ^ s[3] ^ s[2] ^ s[0];
        return {s[RNDSIZE-2:0], fb};
    endfunction

    always_comb begin
        advanced = seed;
        for (int i = 0; i < ADVANCE; i++) begin
            advanced = lfsr_step(advanced);
        end
    end

    // Current seed with the incoming word merged at the active word slot.
    // Word bits landing at or above RNDSIZE simply have no destination.
    always_comb begin
        assembled = seed;
        for (int i = 0; i < RNDSIZE; i++) begin
            if (32'(word_idx) == 32'(i / 32)) begin
                assembled[i] = cfg_word[i % 32];
            end
        end
    end

    assign load_start = cfg_load && (state == S_IDLE || state == S_READY);
    assign word_fire  = cfg_word_valid && (state == S_LOAD);
    assign last_word  = (word_idx == IDXW'(NW - 1));
    assign frame_fire = frame_valid && frame_ready;
    assign run_start  = (state == S_READY) && start && !cfg_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        frame_valid    = 1'b0;
        cfg_word_ready = 1'b0;
        busy           = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_load) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                cfg_word_ready = 1'b1;
                busy           = 1'b1;
                if (word_fire && last_word) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                // A reload request wins over a simultaneous start.
                if (cfg_load) begin
                    state_next = S_LOAD;
                end else if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                frame_valid = 1'b1;
                busy        = 1'b1;
                // Leave only on a handshake so an offered frame is never withdrawn.
                if (frame_ready && (stop || stop_pending)) begin
                    state_next = S_READY;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed          <= '0;
            probability   <= '0;
            count         <= '0;
            word_idx      <= '0;
            zero_seed_err <= 1'b0;
            stop_pending  <= 1'b0;
        end else begin
            if (load_start) begin
                word_idx      <= '0;
                zero_seed_err <= 1'b0;
                count         <= '0;
                stop_pending  <= 1'b0;
            end

            if (word_fire) begin
                word_idx <= word_idx + 1'b1;
                if (last_word && assembled == '0) begin
                    // An all-zero state would lock the LFSR; force a live seed.
                    seed          <= {{(RNDSIZE-1){1'b0}}, 1'b1};
                    zero_seed_err <= 1'b1;
                end else begin
                    seed <= assembled;
                end
            end

            if (run_start) begin
                probability  <= probability_in;
                stop_pending <= 1'b0;
            end

            if (state == S_RUN) begin
                if (frame_fire) begin
                    seed  <= advanced;
                    count <= count + 1'b1;
                    if (stop || stop_pending) begin
                        stop_pending <= 1'b0;
                    end
                end else if (stop) begin
                    stop_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seed_sequencer.sv
// tb/tb_lfsr_seed_sequencer.sv - self-checking bench for lfsr_seed_sequencer
module tb_lfsr_seed_sequencer;

    localparam int NB_SEGMENTS = 7;
    localparam int BITSIZE     = 10;
    localparam int RNDSIZE     = 70;
    localparam int ADVANCE     = 1;
    localparam int CS          = 4;
    localparam logic [RNDSIZE-1:0] TAPS = {1'b1, {(RNDSIZE-5){1'b0}}, 4'b1101};

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_load;
    logic               cfg_word_valid;
    logic [31:0]        cfg_word;
    logic               cfg_word_ready;
    logic [CS-1:0]      probability_in;
    logic               start;
    logic               stop;
    logic               frame_valid;
    logic               frame_ready;
    logic [RNDSIZE-1:0] seed;
    logic [CS-1:0]      probability;
    logic [CS-1:0]      count;
    logic               busy;
    logic               zero_seed_err;

    int tests = 0;
    int fails = 0;

    logic [RNDSIZE-1:0] m_seed;
    logic [CS-1:0]      m_count;
    logic [CS-1:0]      m_prob;
    logic               m_err;
    logic               m_run;
    logic               m_stop_req;

    always #5 clk = ~clk;

    lfsr_seed_sequencer #(
        .NB_SEGMENTS(NB_SEGMENTS),
        .BITSIZE(BITSIZE),
        .RNDSIZE(RNDSIZE),
        .ADVANCE(ADVANCE),
        .COUNTERSIZE(CS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_load(cfg_load),
        .cfg_word_valid(cfg_word_valid),
        .cfg_word(cfg_word),
        .cfg_word_ready(cfg_word_ready),
        .probability_in(probability_in),
        .start(start),
        .stop(stop),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .seed(seed),
        .probability(probability),
        .count(count),
        .busy(busy),
        .zero_seed_err(zero_seed_err)
    );

    // Shift left, new bit = parity of tapped bits; applied ADVANCE times.
    function automatic logic [RNDSIZE-1:0] ref_next(input logic [RNDSIZE-1:0] s);
        logic [RNDSIZE-1:0] r;
        r = s;
        for (int k = 0; k < ADVANCE; k++) begin
            r = (r << 1) | RNDSIZE'(^(r & TAPS));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_seed = '0; m_count = '0; m_prob = '0; m_err = 1'b0; m_run = 1'b0; m_stop_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [31:0] w [3];
        logic [95:0] full;
        int g;
        w[0] = w0; w[1] = w1; w[2] = w2;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cfg_word = w[k];
            cfg_word_valid = 1'b1;
            g = 0;
            while (cfg_word_ready !== 1'b1 && g < 20) begin
                tick();
                g++;
            end
            tests++;
            if (g >= 20) begin
                fails++;
                $display("FAIL load_word_ready: word %0d got ready=%b within 20 cycles, required 1", k, cfg_word_ready);
            end
            tick();
        end
        cfg_word_valid = 1'b0;
        cfg_word = '0;
        full = {w2, w1, w0};
        m_seed = full[RNDSIZE-1:0];
        m_err = (m_seed == '0);
        if (m_err) m_seed = 1;
        m_count = '0; m_run = 1'b0; m_stop_req = 1'b0;
    endtask

    // Drive one cycle of inputs, compare registered outputs with the model,
    // then advance the model by the rules for that cycle.
    task automatic run_cycle(input bit fr, input bit st, input bit sp, input bit cl, input logic [CS-1:0] pin);
        frame_ready = fr; start = st; stop = sp; cfg_load = cl; probability_in = pin;
        tests++; if (frame_valid !== m_run) begin fails++; $display("FAIL frame_valid: got %b required %b", frame_valid, m_run); end
        tests++; if (seed !== m_seed) begin fails++; $display("FAIL seed: got %h required %h", seed, m_seed); end
        tests++; if (count !== m_count) begin fails++; $display("FAIL count: got %0d required %0d", count, m_count); end
        tests++; if (probability !== m_prob) begin fails++; $display("FAIL probability: got %0d required %0d", probability, m_prob); end
        tests++; if (busy !== m_run) begin fails++; $display("FAIL busy: got %b required %b", busy, m_run); end
        tests++; if (zero_seed_err !== m_err) begin fails++; $display("FAIL zero_seed_err: got %b required %b", zero_seed_err, m_err); end
        tests++; if (cfg_word_ready !== 1'b0) begin fails++; $display("FAIL cfg_word_ready: got %b required 0", cfg_word_ready); end
        tick();
        start = 1'b0; stop = 1'b0; cfg_load = 1'b0;
        if (m_run) begin
            if (fr) begin
                m_seed = ref_next(m_seed);
                m_count = m_count + 1'b1;
                if (sp || m_stop_req) begin
                    m_run = 1'b0;
                    m_stop_req = 1'b0;
                end
            end else if (sp) begin
                m_stop_req = 1'b1;
            end
        end else if (st) begin
            m_run = 1'b1;
            m_prob = pin;
            m_stop_req = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        tests++; if (seed !== '0) begin fails++; $display("FAIL %s seed: got %h required 0", tag, seed); end
        tests++; if (probability !== '0) begin fails++; $display("FAIL %s probability: got %0d required 0", tag, probability); end
        tests++; if (count !== '0) begin fails++; $display("FAIL %s count: got %0d required 0", tag, count); end
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL %s frame_valid: got %b required 0", tag, frame_valid); end
        tests++; if (cfg_word_ready !== 1'b0) begin fails++; $display("FAIL %s cfg_word_ready: got %b required 0", tag, cfg_word_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s busy: got %b required 0", tag, busy); end
        tests++; if (zero_seed_err !== 1'b0) begin fails++; $display("FAIL %s zero_seed_err: got %b required 0", tag, zero_seed_err); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_load = 0; cfg_word_valid = 0; cfg_word = '0; probability_in = '0;
        start = 0; stop = 0; frame_ready = 0;
        tick(); tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        model_reset();
        tick();
        check_reset_values("post_reset");
    endtask

    task automatic test_basic();
        logic [RNDSIZE-1:0] exp_s [4];
        exp_s[0] = 70'h1; exp_s[1] = 70'h3; exp_s[2] = 70'h7; exp_s[3] = 70'hE;
        do_load(32'h1, 32'h0, 32'h0);
        tests++; if (seed !== 70'h1) begin fails++; $display("FAIL basic_loaded_seed: got %h required 1", seed); end
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            tests++; if (seed !== exp_s[i]) begin fails++; $display("FAIL basic_seed[%0d]: got %h required %h", i, seed, exp_s[i]); end
            tests++; if (count !== 4'(i)) begin fails++; $display("FAIL basic_count[%0d]: got %0d required %0d", i, count, i); end
            tests++; if (probability !== 4'd4) begin fails++; $display("FAIL basic_prob[%0d]: got %0d required 4", i, probability); end
            run_cycle(1'b1, 1'b0, i == 3, 1'b0, 4'($urandom));
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
    endtask

    task automatic test_zero_seed();
        do_load(32'h0, 32'h0, 32'h0);
        tests++; if (seed !== 70'h1) begin fails++; $display("FAIL zero_seed_value: got %h required 1", seed); end
        tests++; if (zero_seed_err !== 1'b1) begin fails++; $display("FAIL zero_seed_err_set: got %b required 1", zero_seed_err); end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tests++; if (zero_seed_err !== 1'b0) begin fails++; $display("FAIL zero_seed_err_clear: got %b required 0", zero_seed_err); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL load_busy: got %b required 1", busy); end
        // do_load pulses cfg_load again while already in LOAD; it must be ignored.
        do_load($urandom | 32'h1, $urandom, $urandom);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_backpressure();
        do_load(32'h1, 32'h0, 32'h0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'($urandom));
        for (int i = 0; i < 5; i++) begin
            tests++; if (seed !== 70'h1) begin fails++; $display("FAIL bp_seed[%0d]: got %h required 1", i, seed); end
            tests++; if (count !== 4'd0) begin fails++; $display("FAIL bp_count[%0d]: got %0d required 0", i, count); end
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
        end
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));
        tests++; if (seed !== 70'h3) begin fails++; $display("FAIL bp_release_seed: got %h required 3", seed); end
        tests++; if (count !== 4'd1) begin fails++; $display("FAIL bp_release_count: got %0d required 1", count); end
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_wrap();
        do_load($urandom | 32'h8, $urandom, $urandom);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'($urandom));
        for (int i = 0; i < 17; i++) begin
            tests++; if (count !== 4'(i)) begin fails++; $display("FAIL wrap_count[%0d]: got %0d required %0d", i, count, i % 16); end
            run_cycle(1'b1, 1'b0, i == 16, 1'b0, 4'($urandom));
        end
    endtask

    task automatic test_stop_pending();
        logic [RNDSIZE-1:0] s_keep;
        logic [CS-1:0]      c_keep;
        logic [CS-1:0]      p2;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'($urandom));
        run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom));
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
        end
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));
        tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL stop_pending_exit: got frame_valid=%b required 0", frame_valid); end
        s_keep = m_seed; c_keep = m_count;
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'($urandom));
        p2 = 4'($urandom);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, p2);
        tests++; if (seed !== s_keep) begin fails++; $display("FAIL resume_seed: got %h required %h", seed, s_keep); end
        tests++; if (count !== c_keep) begin fails++; $display("FAIL resume_count: got %0d required %0d", count, c_keep); end
        tests++; if (probability !== p2) begin fails++; $display("FAIL resume_prob: got %0d required %0d", probability, p2); end
        run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_reset_mid_load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        cfg_word_valid = 1'b1; cfg_word = 32'hDEAD_BEEF;
        tick();
        cfg_word = 32'h1234_5678;
        tick();
        rst_n = 1'b0;
        #2;
        check_reset_values("mid_load_reset");
        cfg_word_valid = 1'b0; cfg_word = '0;
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        test_basic();
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4 && m_run; k++) begin
                run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
            end
            do_load($urandom, $urandom, $urandom);
            for (int c = 0; c < 50; c++) begin
                run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 9) == 0, m_run && ($urandom_range(0, 15) == 0),
                          4'($urandom));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_zero_seed();
        test_backpressure();
        test_wrap();
        test_stop_pending();
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
